// File: rtl/jpeg_dezigzag.sv
// Inverse zig-zag reorder buffer: accepts 8x8 blocks in JPEG zig-zag order and
// emits them in raster order through two ping-pong banks.
module jpeg_dezigzag #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout,
  output logic [2:0]    dout_row,
  output logic [2:0]    dout_col,
  output logic          dout_last
);

  // Raster address of each zig-zag index; writes scatter, reads stay linear.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DW-1:0] mem [2][64];
  logic          wbank;
  logic          rbank;
  logic [5:0]    wcnt;
  logic [5:0]    rcnt;
  logic [1:0]    full;
  logic          wr_fire;
  logic          rd_fire;

  assign din_ready  = !full[wbank];
  assign dout_valid = full[rbank];
  assign wr_fire    = din_valid & din_ready;
  assign rd_fire    = dout_valid & dout_ready;

  assign dout      = mem[rbank][rcnt];
  assign dout_row  = rcnt[5:3];
  assign dout_col  = rcnt[2:0];
  assign dout_last = dout_valid & (&rcnt);

  // Coefficient storage carries no reset; validity lives entirely in full[].
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wbank][ZZ[wcnt]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= 6'd0;
      rcnt  <= 6'd0;
      full  <= 2'b00;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 6'd1;
        if (&wcnt) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      // The read bank is always full while reading, so it never aliases the write bank.
      if (rd_fire) begin
        rcnt <= rcnt + 6'd1;
        if (&rcnt) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dezigzag.sv
// Scoreboard bench for jpeg_dezigzag: a diagonal-walk zig-zag model predicts the
// raster stream, and a negedge monitor checks every presented output.
module tb_jpeg_dezigzag;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic [2:0]    dout_row;
  logic [2:0]    dout_col;
  logic          dout_last;

  jpeg_dezigzag #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_row(dout_row), .dout_col(dout_col), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [2:0]    row;
    logic [2:0]    col;
    logic          last;
  } exp_t;

  int            compared = 0;
  int            mismatched = 0;
  int            zz_pos [64];
  exp_t          sb [$];
  logic [DW-1:0] blk [$];
  int            blk_start [$];
  int            cur_start = 0;
  int            st_tmp;
  int            cyc = 0;
  bit            lat_check = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Zig-zag order from first principles: walk the 15 anti-diagonals,
  // going up-right on even diagonals and down-left on odd ones.
  function automatic void buildZigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      for (int i = 0; i <= hi - lo; i++) begin
        int r = (s % 2 == 0) ? hi - i : lo + i;
        zz_pos[k] = r * 8 + (s - r);
        k++;
      end
    end
  endfunction

  function automatic void expandBlock();
    logic [DW-1:0] ras [64];
    exp_t e;
    for (int k = 0; k < 64; k++) ras[zz_pos[k]] = blk[k];
    for (int r = 0; r < 64; r++) begin
      e.val  = ras[r];
      e.row  = 3'(r / 8);
      e.col  = 3'(r % 8);
      e.last = (r == 63);
      sb.push_back(e);
    end
    blk.delete();
  endfunction

  function automatic logic readyValue(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ($urandom_range(1) == 1);
      default: return ~dout_ready;
    endcase
  endfunction

  // Monitor: records accepted inputs into the model and checks the presented output
  // against the queue head every cycle, popping only on a handshake.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      blk.delete();
      blk_start.delete();
    end else begin
      if (din_valid && din_ready) begin
        if (blk.size() == 0) cur_start = cyc;
        blk.push_back(din);
        if (blk.size() == 64) begin
          blk_start.push_back(cur_start);
          expandBlock();
        end
      end
      if (!dout_valid) begin
        checkOutput("last_idle", 32'(dout_last), 32'd0);
      end else if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_dout: got 0x%0h at (%0d,%0d), expected no output", dout, dout_row, dout_col);
      end else begin
        checkOutput("dout", 32'({dout, dout_row, dout_col, dout_last}), 32'(sb[0]));
        if (dout_ready) begin
          if (sb[0].row == 3'd0 && sb[0].col == 3'd0 && blk_start.size() > 0) begin
            st_tmp = blk_start.pop_front();
            if (lat_check) checkOutput("latency", 32'(cyc - st_tmp), 32'd64);
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input int vpct, input int rmode, input bit rnd,
                               input int base, output int stalls);
    int sent = 0;
    int budget = 0;
    stalls = 0;
    while (sent < n && budget < 200000) begin
      @(posedge clk); #1;
      din_valid  = ($urandom_range(99) < vpct);
      din        = rnd ? DW'($urandom) : DW'(base + sent);
      dout_ready = readyValue(rmode);
      @(negedge clk);
      if (din_valid && din_ready) sent++;
      else if (din_valid) stalls++;
      budget++;
    end
    if (sent < n) checkOutput("stim_timeout", 32'(sent), 32'(n));
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic drainOut(input int rmode);
    int budget = 0;
    while ((sb.size() != 0 || dout_valid) && budget < 5000) begin
      @(posedge clk); #1;
      din_valid  = 1'b0;
      dout_ready = readyValue(rmode);
      @(negedge clk);
      budget++;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int stalls;
    int acc;
    bit seen;
    buildZigzag();
    rst = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_din_ready", 32'(din_ready), 32'd1);
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_row_col_last", 32'({dout_row, dout_col, dout_last}), 32'd0);
    rst = 1'b0;

    $display("[TB] single block");
    lat_check = 1'b1;
    applyStimulus(64, 100, 1, 1'b0, 0, stalls);
    checkOutput("valid_after_64th", 32'(dout_valid), 32'd1);
    drainOut(1);

    $display("[TB] back-to-back blocks");
    applyStimulus(256, 100, 1, 1'b0, 0, stalls);
    checkOutput("b2b_stalls", 32'(stalls), 32'd0);
    drainOut(1);
    lat_check = 1'b0;

    $display("[TB] full backpressure");
    acc = 0;
    for (int i = 0; i < 130; i++) begin
      @(posedge clk); #1;
      din_valid = 1'b1; din = DW'(1000 + acc); dout_ready = 1'b0;
      @(negedge clk);
      if (din_valid && din_ready) acc++;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    checkOutput("bp_accepted", 32'(acc), 32'd128);
    checkOutput("bp_din_ready", 32'(din_ready), 32'd0);
    checkOutput("bp_dout_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dout_valid && dout_last) begin
        checkOutput("bp_ready_before_last", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("bp_ready_restored", 32'(din_ready), 32'd1);
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_last_seen", 32'(seen), 32'd1);
    drainOut(1);

    $display("[TB] random stall");
    applyStimulus(1280, 50, 2, 1'b1, 0, stalls);
    drainOut(2);

    $display("[TB] reset mid-block");
    applyStimulus(64, 100, 0, 1'b1, 0, stalls);
    applyStimulus(30, 100, 1, 1'b1, 0, stalls);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("mid_rst_din_ready", 32'(din_ready), 32'd1);
    checkOutput("mid_rst_row_col_last", 32'({dout_row, dout_col, dout_last}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(64, 100, 1, 1'b1, 0, stalls);
    drainOut(1);

    $display("[TB] hold stability");
    applyStimulus(64, 100, 0, 1'b1, 0, stalls);
    drainOut(3);

    checkOutput("final_empty", 32'(sb.size() + blk.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jpeg_dezigzag.md
# jpeg_dezigzag

Inverse zig-zag reorder buffer for the JPEG datapath. It accepts 8x8 blocks of coefficients in JPEG zig-zag scan order and emits each block in raster (row-major) order. It is the receive-side counterpart of the encoder's zig-zag stage and sits between entropy/dequantisation and the IDCT in the decode path. Ping-pong double buffering sustains one coefficient per cycle in each direction.

## Interface

Parameters:
- DW, 12, coefficient width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- din_valid  in  1  input coefficient valid.
- din_ready  out  1  block can accept an input coefficient.
- din  in  DW  coefficient; the n-th accepted sample of a block is zig-zag index n.
- dout_valid  out  1  output coefficient valid.
- dout_ready  in  1  downstream accepts the output coefficient.
- dout  out  DW  coefficient at raster position {dout_row, dout_col}.
- dout_row  out  3  raster row, 0..7.
- dout_col  out  3  raster column, 0..7.
- dout_last  out  1  high on the 64th coefficient of a block (row 7, col 7).

## Operation

- Storage: two banks of 64 x DW registers, mem[bank][raster_addr]. Storage is not reset.
- Zig-zag ROM: a 64-entry combinational table zz[k] maps each zig-zag index k to its raster address, using the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Write side state: wbank (1 bit), wcnt (6 bits).
- Read side state: rbank (1 bit), rcnt (6 bits).
- Bank state: full[1:0].
- Write rules:
  - din_ready = !full[wbank].
  - On din_valid & din_ready: mem[wbank][zz[wcnt]] <= din and wcnt increments.
  - When wcnt==63 is accepted: full[wbank] <= 1, wbank toggles, wcnt wraps to 0.
- Read rules:
  - dout_valid = full[rbank].
  - dout = mem[rbank][rcnt], dout_row = rcnt[5:3], dout_col = rcnt[2:0].
  - dout_last = dout_valid & (rcnt==63).
  - On dout_valid & dout_ready: rcnt increments. On rcnt==63: full[rbank] <= 0, rbank toggles, rcnt wraps to 0.
- Simultaneous events: the write side filling one bank and the read side draining the other in the same cycle both take effect. The two sides always work on different banks, so full[] bits are never set and cleared in the same cycle.
- Both banks full: din_ready=0 and input stalls until the read side finishes a bank.
- dout holds stable while dout_valid & !dout_ready.
- Reset mid-block: a partially written or partially read block is discarded. No output follows reset until 64 new samples have been accepted.

## Timing

- Reset values:
  - wbank=0, rbank=0, wcnt=0, rcnt=0, full=2'b00.
  - Therefore din_ready=1, dout_valid=0, dout_last=0, dout_row=0, dout_col=0.
- Latency: if the 64th sample of a block is accepted at edge T, dout_valid rises immediately after T, and raster position 0 can be taken at edge T+1.
- Throughput:
  - With dout_ready held high and din_valid continuous, input never stalls.
  - Output streams at 1 coefficient per cycle, lagging input by 64 cycles.
- Backpressure: dout_ready held low for more than one block period blocks the input once the second bank fills. din_ready falls in the cycle after the 128th unread sample is accepted.
- din_ready and dout_valid are decoded from registered state only. There is no combinational path from din_valid to dout_valid or from dout_ready to din_ready.

## Test plan

- Single block:
  - Stimulus: after reset, feed din = k for k = 0..63, with dout_ready=1.
  - Response: raster stream is 0,1,5,6,14,15,27,28 for row 0 and 2,4,7,13,16,26,29,42 for row 1, ending with 63. dout_last is high only on {7,7}.
- Back-to-back blocks:
  - Stimulus: 4 blocks, continuous din_valid, values k + 64·b.
  - Response: din_ready never drops. Block b outputs begin 64 cycles after its input begins, each equal to its inverse-table value + 64·b.
- Full backpressure:
  - Stimulus: dout_ready=0 while 130 samples are offered.
  - Response: exactly 128 are accepted, din_ready=0 afterwards, and dout stays at the block-0 raster-0 value. Releasing dout_ready drains block 0 and restores din_ready one cycle after its dout_last handshake.
- Random stall:
  - Stimulus: random din_valid and dout_ready at 50% over 20 blocks.
  - Response: output matches the reference inverse-zig-zag model, with no drops or duplicates.
- Reset mid-block:
  - Stimulus: assert rst after 30 samples of block 1 while block 0 is half read.
  - Response: outputs immediately return to reset values. The next 64 samples form a clean block whose first output is its zig-zag index 0 value.
- Hold stability:
  - Stimulus: dout_valid=1 with dout_ready toggled 0/1 every cycle.
  - Response: dout, row, and col change only after handshake cycles.
